// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the
// traffic phase sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    RED1     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    RED2     = 3'd5,
    WALK     = 3'd6
  } phase_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic logic [2:0] main_of(
    input phase_e p
  );
    unique case (p)
      MAIN_GRN: main_of = LIGHT_GRN;
      MAIN_YEL: main_of = LIGHT_YEL;
      default:  main_of = LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_of(
    input phase_e p
  );
    unique case (p)
      SIDE_GRN: side_of = LIGHT_GRN;
      SIDE_YEL: side_of = LIGHT_YEL;
      default:  side_of = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_seq_timer.sv
// In-phase tick counter; done flags the
// terminal tick of the current duration.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign done = tick && (cnt == dur - ONE);

  // count ticks, restart at each phase change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/traffic_phase_seq.sv
// Two-approach traffic phase sequencer with
// pedestrian walk phase and change pulse.
module traffic_phase_seq
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 6,
  parameter int MAIN_GREEN_T = 11,
  parameter int SIDE_GREEN_T = 11,
  parameter int YELLOW_T     = 2,
  parameter int ALL_RED_T    = 2,
  parameter int WALK_T       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase,
  output logic       enable
);

  localparam int MAXD = (1 << CNT_W) - 1;

  localparam bit DUR_OK =
    MAIN_GREEN_T >= 1 && MAIN_GREEN_T <= MAXD &&
    SIDE_GREEN_T >= 1 && SIDE_GREEN_T <= MAXD &&
    YELLOW_T     >= 1 && YELLOW_T     <= MAXD &&
    ALL_RED_T    >= 1 && ALL_RED_T    <= MAXD &&
    WALK_T       >= 1 && WALK_T       <= MAXD;

  if (!DUR_OK) begin : g_bad_dur
    $error("phase duration outside 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] D_MG = CNT_W'(MAIN_GREEN_T);
  localparam logic [CNT_W-1:0] D_SG = CNT_W'(SIDE_GREEN_T);
  localparam logic [CNT_W-1:0] D_Y  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] D_R  = CNT_W'(ALL_RED_T);
  localparam logic [CNT_W-1:0] D_W  = CNT_W'(WALK_T);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dur;
  logic             done;
  logic             pend_d;
  logic             en_d;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (done),
    .dur   (dur),
    .done  (done)
  );

  // duration of the phase being timed
  always_comb begin
    dur = D_MG;
    unique case (phase_q)
      MAIN_GRN: dur = D_MG;
      MAIN_YEL: dur = D_Y;
      RED1:     dur = D_R;
      SIDE_GRN: dur = D_SG;
      SIDE_YEL: dur = D_Y;
      RED2:     dur = D_R;
      WALK:     dur = D_W;
      default:  dur = D_MG;
    endcase
  end

  // next phase, pedestrian latch and change pulse
  always_comb begin
    phase_d = phase_q;
    if (done) begin
      unique case (phase_q)
        MAIN_GRN: phase_d = MAIN_YEL;
        MAIN_YEL: phase_d = RED1;
        RED1:     phase_d = SIDE_GRN;
        SIDE_GRN: phase_d = SIDE_YEL;
        SIDE_YEL: phase_d = RED2;
        RED2:     phase_d = ped_pending ? WALK : MAIN_GRN;
        WALK:     phase_d = MAIN_GRN;
        default:  phase_d = MAIN_GRN;
      endcase
    end
    pend_d = ped_pending;
    if (phase_d == WALK && phase_q != WALK) begin
      pend_d = 1'b0;
    end else if (ped_req && phase_q != WALK) begin
      pend_d = 1'b1;
    end
    en_d = (phase_d != phase_q);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= MAIN_GRN;
      main_light  <= LIGHT_GRN;
      side_light  <= LIGHT_RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      enable      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      main_light  <= main_of(phase_d);
      side_light  <= side_of(phase_d);
      walk        <= (phase_d == WALK);
      ped_pending <= pend_d;
      enable      <= en_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Directed bench for traffic_phase_seq:
// default timing plus an all-ones variant.
module tb_traffic_phase_seq;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ped_req;
  logic [2:0] main_light, side_light, phase;
  logic       walk, ped_pending, enable;

  logic       tick1;
  logic [2:0] main1, side1, phase1;
  logic       walk1, pend1, en1;

  int checks = 0;
  int errors = 0;
  int en_q[$];

  traffic_phase_seq dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase),
    .enable      (enable)
  );

  traffic_phase_seq #(
    .CNT_W(4), .MAIN_GREEN_T(1), .SIDE_GREEN_T(1),
    .YELLOW_T(1), .ALL_RED_T(1), .WALK_T(1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick1),
    .ped_req     (1'b0),
    .main_light  (main1),
    .side_light  (side1),
    .walk        (walk1),
    .ped_pending (pend1),
    .phase       (phase1),
    .enable      (en1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_en(input int i);
    foreach (en_q[k]) if (en_q[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_main", 32'(main_light), 32'b001);
    chk("rst_side", 32'(side_light), 32'b100);
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_pend", 32'(ped_pending), 32'd0);
    chk("rst_en", 32'(enable), 32'd0);
    rst = 1'b0;
  endtask

  task automatic run(
    input int n,   input int rlo, input int rhi,
    input int wlo, input int whi,
    input int plo, input int phi
  );
    for (int i = 1; i <= n; i++) begin
      ped_req = (i >= rlo && i <= rhi);
      step(1'b1);
      chk($sformatf("en_t%0d", i),
          32'(enable), 32'(in_en(i)));
      chk($sformatf("walk_t%0d", i),
          32'(walk), 32'(i >= wlo && i <= whi));
      chk($sformatf("pend_t%0d", i),
          32'(ped_pending), 32'(i >= plo && i <= phi));
      if (walk)
        chk("walk_lights", {26'd0, main_light, side_light},
            32'b100100);
      step(1'b0);
      chk($sformatf("en_gap_t%0d", i), 32'(enable), 32'd0);
    end
    ped_req = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1;
    tick = 1'b0;
    tick1 = 1'b1;
    ped_req = 1'b0;

    // plain cycle, no pedestrian
    do_reset();
    en_q = '{11, 13, 15, 26, 28, 30};
    run(30, 1, 0, 1, 0, 1, 0);
    chk("t1_phase", 32'(phase), 32'd0);
    chk("t1_main", 32'(main_light), 32'b001);

    // single pedestrian press at tick 5
    do_reset();
    en_q = '{11, 13, 15, 26, 28, 30, 40};
    run(40, 5, 5, 30, 39, 5, 29);
    chk("t2_phase", 32'(phase), 32'd0);

    // request held through walk entry, then dropped
    do_reset();
    en_q = '{11, 13, 15, 26, 28, 30, 40,
             51, 53, 55, 66, 68, 70};
    run(70, 1, 35, 30, 39, 1, 29);
    chk("t3_phase", 32'(phase), 32'd0);

    // async reset in side green with request pending
    do_reset();
    en_q = '{11, 13, 15};
    run(20, 3, 3, 1, 0, 3, 20);
    chk("t4_pre_phase", 32'(phase), 32'd3);
    chk("t4_pre_pend", 32'(ped_pending), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t4_phase", 32'(phase), 32'd0);
    chk("t4_main", 32'(main_light), 32'b001);
    chk("t4_side", 32'(side_light), 32'b100);
    chk("t4_pend", 32'(ped_pending), 32'd0);
    chk("t4_en", 32'(enable), 32'd0);

    // ticks during reset are ignored
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_rst_phase1", 32'(phase1), 32'd0);
    chk("t5_rst_en1", 32'(en1), 32'd0);
    tick = 1'b0;
    rst = 1'b0;

    // one-tick durations, tick held high
    p = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      p = (p == 5) ? 0 : p + 1;
      chk($sformatf("d1_phase_c%0d", k), 32'(phase1), 32'(p));
      chk($sformatf("d1_en_c%0d", k), 32'(en1), 32'd1);
      chk($sformatf("d1_lights_c%0d", k),
          {29'd0, $onehot(main1), $onehot(side1),
           (main1 == LIGHT_RED || side1 == LIGHT_RED)},
          32'b111);
    end

    // counting restarts from zero after reset
    chk("t5_phase", 32'(phase), 32'd0);
    en_q = '{11};
    run(11, 1, 0, 1, 0, 1, 0);
    chk("t5_post_phase", 32'(phase), 32'd1);
    chk("t5_post_main", 32'(main_light), 32'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
